// File: rtl/stk_mpipe.sv
// Multi-engine LIFO pipeline: ENGS_N linked-list stacks share one DEPTH-entry pool with a free list.
// Round-robin admission, one registered execute stage, and a walking FSM for stack clears.
module stk_mpipe #(
    parameter int unsigned ENGS_N = 4,
    parameter int unsigned W      = 128,
    parameter int unsigned DEPTH  = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned EID_W = $clog2(ENGS_N)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [ENGS_N-1:0]     i_cmd_vld,
    input  logic [ENGS_N*2-1:0]   i_cmd_opcode,
    input  logic [ENGS_N*W-1:0]   i_cmd_dat,
    output logic [ENGS_N-1:0]     o_cmd_ack,
    output logic                  o_rsp_vld,
    output logic [EID_W-1:0]      o_rsp_engid,
    output logic [1:0]            o_rsp_opcode,
    output logic                  o_rsp_err,
    output logic [W-1:0]          o_rsp_dat,
    output logic [ENGS_N-1:0]     o_empty,
    output logic [CNT_W-1:0]      o_free_cnt
);

    typedef enum logic [0:0] {StIdle, StWalk} state_e;

    localparam logic [1:0] OpNop  = 2'd0;
    localparam logic [1:0] OpPush = 2'd1;
    localparam logic [1:0] OpPop  = 2'd2;
    localparam logic [1:0] OpClr  = 2'd3;

    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [PTR_W-1:0] next_q [DEPTH];
    logic [PTR_W-1:0] next_d [DEPTH];
    logic [PTR_W-1:0] head_q [ENGS_N];
    logic [PTR_W-1:0] head_d [ENGS_N];
    logic [CNT_W-1:0] occ_q  [ENGS_N];
    logic [CNT_W-1:0] occ_d  [ENGS_N];

    logic [PTR_W-1:0] free_head_q, free_head_d;
    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
    state_e           state_q, state_d;
    logic [EID_W-1:0] walk_eng_q, walk_eng_d;
    logic [CNT_W-1:0] walk_cnt_q, walk_cnt_d;
    logic [EID_W-1:0] last_grant_q, last_grant_d;

    logic             ex_vld_q, ex_vld_d;
    logic [EID_W-1:0] ex_eng_q, ex_eng_d;
    logic [1:0]       ex_op_q, ex_op_d;
    logic [W-1:0]     ex_dat_q, ex_dat_d;

    logic             rsp_vld_q, rsp_vld_d;
    logic [EID_W-1:0] rsp_engid_q, rsp_engid_d;
    logic [1:0]       rsp_op_q, rsp_op_d;
    logic             rsp_err_q, rsp_err_d;
    logic [W-1:0]     rsp_dat_q, rsp_dat_d;

    logic [1:0]       opc    [ENGS_N];
    logic [W-1:0]     dat_in [ENGS_N];
    logic [EID_W-1:0] cand;
    logic [EID_W-1:0] grant_idx;
    logic             grant_any;
    logic             busy;
    logic             accept;
    logic             fr_en;
    logic [EID_W-1:0] fr_eng;
    logic [PTR_W-1:0] fr_ent;

    always_comb begin
        for (int i = 0; i < ENGS_N; i++) begin
            opc[i]    = i_cmd_opcode[2*i +: 2];
            dat_in[i] = i_cmd_dat[W*i +: W];
        end
    end

    // Search starts one past the last grant so every requester is served in turn.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant_q;
        cand      = '0;
        for (int k = 0; k < ENGS_N; k++) begin
            cand = EID_W'((int'(last_grant_q) + 1 + k) % ENGS_N);
            if (!grant_any && i_cmd_vld[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign busy   = (ex_vld_q && (ex_op_q == OpClr)) || (state_q == StWalk);
    assign accept = grant_any && !busy && arst_n;

    always_comb begin
        for (int i = 0; i < ENGS_N; i++) begin
            o_cmd_ack[i] = accept && (grant_idx == EID_W'(i));
            o_empty[i]   = (occ_q[i] == '0);
        end
    end

    always_comb begin
        last_grant_d = accept ? grant_idx : last_grant_q;
        ex_vld_d     = accept && (opc[grant_idx] != OpNop);
        ex_eng_d     = grant_idx;
        ex_op_d      = opc[grant_idx];
        ex_dat_d     = dat_in[grant_idx];
    end

    always_comb begin
        data_d      = data_q;
        next_d      = next_q;
        head_d      = head_q;
        occ_d       = occ_q;
        free_head_d = free_head_q;
        free_cnt_d  = free_cnt_q;
        state_d     = state_q;
        walk_eng_d  = walk_eng_q;
        walk_cnt_d  = walk_cnt_q;
        rsp_vld_d   = 1'b0;
        rsp_engid_d = rsp_engid_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        fr_en       = 1'b0;
        fr_eng      = '0;
        fr_ent      = '0;

        if (state_q == StWalk) begin
            fr_en      = 1'b1;
            fr_eng     = walk_eng_q;
            walk_cnt_d = walk_cnt_q + CNT_W'(1);
            if (occ_q[walk_eng_q] == CNT_W'(1)) begin
                state_d     = StIdle;
                rsp_vld_d   = 1'b1;
                rsp_engid_d = walk_eng_q;
                rsp_op_d    = OpClr;
                rsp_err_d   = 1'b0;
                rsp_dat_d   = W'(walk_cnt_q + CNT_W'(1));
            end
        end else if (ex_vld_q) begin
            rsp_vld_d   = 1'b1;
            rsp_engid_d = ex_eng_q;
            rsp_op_d    = ex_op_q;
            rsp_err_d   = 1'b0;
            rsp_dat_d   = '0;
            case (ex_op_q)
                OpPush: begin
                    if (free_cnt_q != '0) begin
                        data_d[free_head_q] = ex_dat_q;
                        next_d[free_head_q] = head_q[ex_eng_q];
                        head_d[ex_eng_q]    = free_head_q;
                        free_head_d         = next_q[free_head_q];
                        free_cnt_d          = free_cnt_q - CNT_W'(1);
                        occ_d[ex_eng_q]     = occ_q[ex_eng_q] + CNT_W'(1);
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
                OpPop: begin
                    if (occ_q[ex_eng_q] != '0) begin
                        fr_en     = 1'b1;
                        fr_eng    = ex_eng_q;
                        rsp_dat_d = data_q[head_q[ex_eng_q]];
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
                OpClr: begin
                    if (occ_q[ex_eng_q] != '0) begin
                        fr_en  = 1'b1;
                        fr_eng = ex_eng_q;
                        if (occ_q[ex_eng_q] == CNT_W'(1)) begin
                            rsp_dat_d = W'(1);
                        end else begin
                            // Response is deferred until the walk frees the last entry.
                            rsp_vld_d  = 1'b0;
                            state_d    = StWalk;
                            walk_eng_d = ex_eng_q;
                            walk_cnt_d = CNT_W'(1);
                        end
                    end
                end
                default: rsp_vld_d = 1'b0;
            endcase
        end

        if (fr_en) begin
            fr_ent         = head_q[fr_eng];
            head_d[fr_eng] = next_q[fr_ent];
            next_d[fr_ent] = free_head_q;
            free_head_d    = fr_ent;
            free_cnt_d     = free_cnt_q + CNT_W'(1);
            occ_d[fr_eng]  = occ_q[fr_eng] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                next_q[i] <= PTR_W'(i + 1);
            end
            for (int i = 0; i < ENGS_N; i++) begin
                head_q[i] <= '0;
                occ_q[i]  <= '0;
            end
            free_head_q  <= '0;
            free_cnt_q   <= CNT_W'(DEPTH);
            state_q      <= StIdle;
            walk_eng_q   <= '0;
            walk_cnt_q   <= '0;
            last_grant_q <= EID_W'(ENGS_N - 1);
            ex_vld_q     <= 1'b0;
            ex_eng_q     <= '0;
            ex_op_q      <= OpNop;
            ex_dat_q     <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_engid_q  <= '0;
            rsp_op_q     <= OpNop;
            rsp_err_q    <= 1'b0;
            rsp_dat_q    <= '0;
        end else begin
            data_q       <= data_d;
            next_q       <= next_d;
            head_q       <= head_d;
            occ_q        <= occ_d;
            free_head_q  <= free_head_d;
            free_cnt_q   <= free_cnt_d;
            state_q      <= state_d;
            walk_eng_q   <= walk_eng_d;
            walk_cnt_q   <= walk_cnt_d;
            last_grant_q <= last_grant_d;
            ex_vld_q     <= ex_vld_d;
            ex_eng_q     <= ex_eng_d;
            ex_op_q      <= ex_op_d;
            ex_dat_q     <= ex_dat_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_engid_q  <= rsp_engid_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
            rsp_dat_q    <= rsp_dat_d;
        end
    end

    assign o_rsp_vld    = rsp_vld_q;
    assign o_rsp_engid  = rsp_engid_q;
    assign o_rsp_opcode = rsp_op_q;
    assign o_rsp_err    = rsp_err_q;
    assign o_rsp_dat    = rsp_dat_q;
    assign o_free_cnt   = free_cnt_q;

endmodule

// File: tb/tb_stk_mpipe.sv
// Directed bench for stk_mpipe: vector table of single commands plus pipelined, arbitration,
// pool-full, clear-walk and reset-abort sequences.
module tb_stk_mpipe;

    localparam int ENGS_N = 4;
    localparam int W      = 128;
    localparam int DEPTH  = 64;

    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] PSH = 2'd1;
    localparam logic [1:0] POP = 2'd2;
    localparam logic [1:0] CLR = 2'd3;

    logic                clk = 1'b0;
    logic                arst_n;
    logic [ENGS_N-1:0]   i_cmd_vld;
    logic [ENGS_N*2-1:0] i_cmd_opcode;
    logic [ENGS_N*W-1:0] i_cmd_dat;
    logic [ENGS_N-1:0]   o_cmd_ack;
    logic                o_rsp_vld;
    logic [1:0]          o_rsp_engid;
    logic [1:0]          o_rsp_opcode;
    logic                o_rsp_err;
    logic [W-1:0]        o_rsp_dat;
    logic [ENGS_N-1:0]   o_empty;
    logic [6:0]          o_free_cnt;

    int n_checks = 0;
    int n_err    = 0;

    stk_mpipe #(.ENGS_N(ENGS_N), .W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_cmd_vld    (i_cmd_vld),
        .i_cmd_opcode (i_cmd_opcode),
        .i_cmd_dat    (i_cmd_dat),
        .o_cmd_ack    (o_cmd_ack),
        .o_rsp_vld    (o_rsp_vld),
        .o_rsp_engid  (o_rsp_engid),
        .o_rsp_opcode (o_rsp_opcode),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_dat    (o_rsp_dat),
        .o_empty      (o_empty),
        .o_free_cnt   (o_free_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         eng;
        logic [1:0] op;
        logic [127:0] dat;
        logic       err;
        logic [127:0] rdat;
        int         free;
        logic [3:0] empty;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmd();
        i_cmd_vld    = '0;
        i_cmd_opcode = '0;
        i_cmd_dat    = '0;
    endtask

    task automatic set_cmd(input int eng, input logic [1:0] op, input logic [127:0] dat);
        i_cmd_vld[eng]           = 1'b1;
        i_cmd_opcode[eng*2 +: 2] = op;
        i_cmd_dat[eng*W +: W]    = dat;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        clear_cmd();
        next_cyc();
        next_cyc();
        arst_n = 1'b1;
        next_cyc();
    endtask

    // Single isolated command: ack in the issue cycle, response two cycles later.
    task automatic do_cmd(input string name, input int eng, input logic [1:0] op,
                          input logic [127:0] dat, input logic xerr, input logic [127:0] xdat,
                          input int xfree, input logic [3:0] xempty);
        clear_cmd();
        set_cmd(eng, op, dat);
        #3;
        check({name, " ack"}, 128'(o_cmd_ack), 128'(1) << eng);
        next_cyc();
        clear_cmd();
        next_cyc();
        check({name, " rsp_vld"}, 128'(o_rsp_vld), 128'(1));
        check({name, " engid"}, 128'(o_rsp_engid), 128'(eng));
        check({name, " opcode"}, 128'(o_rsp_opcode), 128'(op));
        check({name, " err"}, 128'(o_rsp_err), 128'(xerr));
        check({name, " dat"}, o_rsp_dat, xdat);
        check({name, " free_cnt"}, 128'(o_free_cnt), 128'(xfree));
        check({name, " empty"}, 128'(o_empty), 128'(xempty));
    endtask

    task automatic fill_and_overflow(input string name);
        int acks = 0;
        for (int c = 0; c < DEPTH; c++) begin
            clear_cmd();
            set_cmd(1, PSH, 128'(c));
            #3;
            if (o_cmd_ack == 4'b0010) acks++;
            next_cyc();
        end
        clear_cmd();
        next_cyc();
        check({name, " fill acks"}, 128'(acks), 128'(DEPTH));
        check({name, " fill free_cnt"}, 128'(o_free_cnt), 128'(0));
        check({name, " fill empty"}, 128'(o_empty), 128'(4'b1101));
        do_cmd({name, " push full"}, 2, PSH, 128'h77, 1'b1, 128'h0, 0, 4'b1101);
        do_cmd({name, " pop empty"}, 2, POP, 128'h0, 1'b1, 128'h0, 0, 4'b1101);
        do_cmd({name, " pop top"}, 1, POP, 128'h0, 1'b0, 128'(DEPTH - 1), 1, 4'b1101);
        do_cmd({name, " push last"}, 2, PSH, 128'h99, 1'b0, 128'h0, 0, 4'b1001);
    endtask

    logic [1:0]   a_op  [6];
    logic [127:0] a_dat [6];
    logic [127:0] a_exp [6];

    initial begin
        arst_n = 1'b0;
        clear_cmd();

        vecs[0]  = '{0, PSH, 128'hA,    1'b0, 128'h0,    63, 4'b1110};
        vecs[1]  = '{0, PSH, 128'hB,    1'b0, 128'h0,    62, 4'b1110};
        vecs[2]  = '{0, PSH, 128'hC,    1'b0, 128'h0,    61, 4'b1110};
        vecs[3]  = '{0, POP, 128'h0,    1'b0, 128'hC,    62, 4'b1110};
        vecs[4]  = '{0, POP, 128'h0,    1'b0, 128'hB,    63, 4'b1110};
        vecs[5]  = '{0, POP, 128'h0,    1'b0, 128'hA,    64, 4'b1111};
        vecs[6]  = '{2, POP, 128'h0,    1'b1, 128'h0,    64, 4'b1111};
        vecs[7]  = '{1, PSH, 128'h1234, 1'b0, 128'h0,    63, 4'b1101};
        vecs[8]  = '{3, PSH, 128'h55,   1'b0, 128'h0,    62, 4'b0101};
        vecs[9]  = '{1, POP, 128'h0,    1'b0, 128'h1234, 63, 4'b0111};
        vecs[10] = '{3, POP, 128'h0,    1'b0, 128'h55,   64, 4'b1111};
        vecs[11] = '{2, CLR, 128'h0,    1'b0, 128'h0,    64, 4'b1111};

        a_op  = '{PSH, PSH, PSH, POP, POP, POP};
        a_dat = '{128'hA, 128'hB, 128'hC, 128'h0, 128'h0, 128'h0};
        a_exp = '{128'h0, 128'h0, 128'h0, 128'hC, 128'hB, 128'hA};

        // Reset values, with every engine requesting during reset.
        for (int e = 0; e < ENGS_N; e++) set_cmd(e, PSH, 128'h1);
        #3;
        check("reset ack", 128'(o_cmd_ack), 128'(0));
        do_reset();
        check("reset rsp_vld", 128'(o_rsp_vld), 128'(0));
        check("reset engid", 128'(o_rsp_engid), 128'(0));
        check("reset opcode", 128'(o_rsp_opcode), 128'(0));
        check("reset err", 128'(o_rsp_err), 128'(0));
        check("reset dat", o_rsp_dat, 128'(0));
        check("reset empty", 128'(o_empty), 128'(4'b1111));
        check("reset free_cnt", 128'(o_free_cnt), 128'(DEPTH));

        // Round robin with all engines pushing continuously.
        for (int c = 0; c < 8; c++) begin
            clear_cmd();
            for (int e = 0; e < ENGS_N; e++) set_cmd(e, PSH, 128'(16'h100 * e + c));
            #3;
            check("rr grant", 128'(o_cmd_ack), 128'(1) << (c % 4));
            next_cyc();
        end
        clear_cmd();
        next_cyc();
        check("rr free_cnt", 128'(o_free_cnt), 128'(56));
        check("rr empty", 128'(o_empty), 128'(4'b0000));
        do_cmd("rr pop e2 a", 2, POP, 128'h0, 1'b0, 128'h206, 57, 4'b0000);
        do_cmd("rr pop e2 b", 2, POP, 128'h0, 1'b0, 128'h202, 58, 4'b0100);

        // Vector table of isolated commands.
        do_reset();
        for (int v = 0; v < 12; v++) begin
            do_cmd($sformatf("vec%0d", v), vecs[v].eng, vecs[v].op, vecs[v].dat, vecs[v].err,
                   vecs[v].rdat, vecs[v].free, vecs[v].empty);
        end

        // Back-to-back same-engine PUSH/POP at full throughput.
        for (int c = 0; c < 8; c++) begin
            if (c >= 2) begin
                check($sformatf("b2b rsp_vld %0d", c - 2), 128'(o_rsp_vld), 128'(1));
                check($sformatf("b2b opcode %0d", c - 2), 128'(o_rsp_opcode), 128'(a_op[c-2]));
                check($sformatf("b2b dat %0d", c - 2), o_rsp_dat, a_exp[c-2]);
                check($sformatf("b2b err %0d", c - 2), 128'(o_rsp_err), 128'(0));
            end
            clear_cmd();
            if (c < 6) set_cmd(0, a_op[c], a_dat[c]);
            #3;
            if (c < 6) check($sformatf("b2b ack %0d", c), 128'(o_cmd_ack), 128'(1));
            next_cyc();
        end
        clear_cmd();
        check("b2b free_cnt", 128'(o_free_cnt), 128'(64));
        check("b2b empty", 128'(o_empty), 128'(4'b1111));

        // CLR of a 5-entry stack with a competing PUSH pending from engine 0.
        for (int c = 0; c < 5; c++) begin
            clear_cmd();
            set_cmd(3, PSH, 128'(8'h30 + c));
            next_cyc();
        end
        clear_cmd();
        set_cmd(3, CLR, 128'h0);
        #3;
        check("clr5 ack T", 128'(o_cmd_ack), 128'(4'b1000));
        next_cyc();
        clear_cmd();
        set_cmd(0, PSH, 128'hE0);
        for (int j = 1; j <= 6; j++) begin
            check($sformatf("clr5 free_cnt T+%0d", j), 128'(o_free_cnt), 128'(58 + j));
            if (j >= 2 && j <= 5) begin
                check($sformatf("clr5 rsp_vld T+%0d", j), 128'(o_rsp_vld), 128'(0));
            end
            if (j == 6) begin
                check("clr5 rsp_vld", 128'(o_rsp_vld), 128'(1));
                check("clr5 engid", 128'(o_rsp_engid), 128'(3));
                check("clr5 opcode", 128'(o_rsp_opcode), 128'(CLR));
                check("clr5 err", 128'(o_rsp_err), 128'(0));
                check("clr5 dat", o_rsp_dat, 128'(5));
                check("clr5 empty", 128'(o_empty), 128'(4'b1111));
            end
            #3;
            check($sformatf("clr5 ack T+%0d", j), 128'(o_cmd_ack),
                  (j <= 5) ? 128'(0) : 128'(4'b0001));
            next_cyc();
        end
        clear_cmd();
        next_cyc();
        check("clr5 push rsp engid", 128'(o_rsp_engid), 128'(0));
        check("clr5 push rsp opcode", 128'(o_rsp_opcode), 128'(PSH));
        check("clr5 push free_cnt", 128'(o_free_cnt), 128'(63));

        // CLR of an empty stack: acks blocked for one cycle only.
        clear_cmd();
        set_cmd(2, CLR, 128'h0);
        #3;
        check("clr0 ack T", 128'(o_cmd_ack), 128'(4'b0100));
        next_cyc();
        clear_cmd();
        set_cmd(1, PSH, 128'h11);
        #3;
        check("clr0 ack T+1", 128'(o_cmd_ack), 128'(0));
        next_cyc();
        check("clr0 rsp_vld", 128'(o_rsp_vld), 128'(1));
        check("clr0 engid", 128'(o_rsp_engid), 128'(2));
        check("clr0 opcode", 128'(o_rsp_opcode), 128'(CLR));
        check("clr0 err", 128'(o_rsp_err), 128'(0));
        check("clr0 dat", o_rsp_dat, 128'(0));
        #3;
        check("clr0 ack T+2", 128'(o_cmd_ack), 128'(4'b0010));
        next_cyc();
        clear_cmd();
        next_cyc();

        // Pool exhaustion from a clean reset.
        do_reset();
        fill_and_overflow("pool");

        // Reset asserted in the middle of a CLR walk.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            clear_cmd();
            set_cmd(3, PSH, 128'(c));
            next_cyc();
        end
        clear_cmd();
        set_cmd(3, CLR, 128'h0);
        next_cyc();
        clear_cmd();
        next_cyc();
        arst_n = 1'b0;
        for (int e = 0; e < ENGS_N; e++) set_cmd(e, PSH, 128'h5);
        #2;
        check("abort ack", 128'(o_cmd_ack), 128'(0));
        check("abort rsp_vld", 128'(o_rsp_vld), 128'(0));
        check("abort engid", 128'(o_rsp_engid), 128'(0));
        check("abort opcode", 128'(o_rsp_opcode), 128'(0));
        check("abort err", 128'(o_rsp_err), 128'(0));
        check("abort dat", o_rsp_dat, 128'(0));
        check("abort empty", 128'(o_empty), 128'(4'b1111));
        check("abort free_cnt", 128'(o_free_cnt), 128'(DEPTH));
        next_cyc();
        clear_cmd();
        arst_n = 1'b1;
        next_cyc();
        fill_and_overflow("abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stk_mpipe.md
# stk_mpipe

Parametrised multi-engine stack pipeline: ENGS_N engines share a single pool of DEPTH entries, each engine owning one LIFO stack built as a linked list over the pool, with unused entries held on a free list. One command per cycle is admitted by a round-robin arbiter and executed in a registered stage; responses return on a single shared channel. CLR walks the target stack back onto the free list through a multi-cycle state machine. The block is the generalised successor to the fixed-width stack pipe in the stk subsystem.

## Interface
- ENGS_N, 4: number of engines/stacks (≥2).
- W, 128: data width.
- DEPTH, 64: shared entries (power of 2, ≥2); PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1).

- clk  in  1  clock; single clock domain.
- arst_n  in  1  asynchronous active-low reset.
- i_cmd_vld  in  ENGS_N  per-engine command request.
- i_cmd_opcode  in  ENGS_N×2  0 NOP, 1 PUSH, 2 POP, 3 CLR.
- i_cmd_dat  in  ENGS_N×W  PUSH data.
- o_cmd_ack  out  ENGS_N  one-hot grant (combinational); command is consumed on vld&ack.
- o_rsp_vld  out  1  response valid (registered).
- o_rsp_engid  out  $clog2(ENGS_N)  responding engine.
- o_rsp_opcode  out  2  echoed opcode.
- o_rsp_err  out  1  PUSH with pool full / POP with stack empty.
- o_rsp_dat  out  W  POP data; CLR: zero-extended count freed; PUSH: 0.
- o_empty  out  ENGS_N  per-stack empty (registered state).
- o_free_cnt  out  CNT_W  free-list length.

## Operation
- State: data[DEPTH], next[DEPTH], per-engine head ptr + head_vld, free_head, free_cnt; all flops.
- Arbiter: round-robin over i_cmd_vld with opcode≠NOP; NOP with vld is acked and dropped (no response). Priority starts at last_grant+1; last_grant resets to ENGS_N-1 (engine 0 first). Requester holds vld/opcode/dat stable until ack.
- EX stage (registered command) executes and updates state at its clock edge:
  - PUSH, free_cnt>0: e=free_head; data[e]=dat; next[e]=head; head=e; free_head=next[e] (old); free_cnt−1. Else err=1, no state change.
  - POP, stack non-empty: rsp_dat=data[head]; entry returned to free-list head; head=next; free_cnt+1. Else err=1, rsp_dat=0.
  - CLR: see FSM.
- FSM (IDLE, WALK): CLR in EX frees the head entry if present. If entries remain → WALK, freeing one entry per cycle until stack empty, counting frees. Response issued in the cycle after the last free (or after EX if stack empty, dat=0).
- Busy: o_cmd_ack = 0 while CLR is in EX or FSM is in WALK.
- Reset: free list = 0→1→…→DEPTH-1 (next[i]=i+1), free_head=0, free_cnt=DEPTH, all stacks empty, FSM IDLE, EX empty. Reset mid-CLR aborts the walk; the pool returns to the reset state.
- Invariant: free_cnt + Σ stack occupancies = DEPTH at all times.

## Timing
- Accept at cycle T → EX at T+1 → o_rsp_* valid at T+2 (one cycle, no backpressure). Throughput 1 command/cycle for PUSH/POP, including back-to-back same-engine commands. No forwarding is required: state is updated before the next EX.
- CLR of k entries: frees at T+1..T+k; response at T+max(k,1)+1; acks suppressed for cycles T+1..T+max(k,1).
- o_empty and o_free_cnt reflect the EX update at the following cycle (T+2).
- Reset values: o_cmd_ack 0 (while arst_n low), o_rsp_vld 0, o_rsp_engid 0, o_rsp_opcode 0, o_rsp_err 0, o_rsp_dat 0, o_empty all 1, o_free_cnt DEPTH.

## Test plan
- Engine 0 PUSH 0xA, 0xB, 0xC back-to-back, then 3 POPs → responses at T+2 each; POP data 0xC, 0xB, 0xA; o_free_cnt returns to 64; o_empty[0]=1.
- All 4 engines hold PUSH continuously → grants cycle 0,1,2,3,0… one per cycle; after 8 cycles each stack holds 2 entries.
- Fill the pool with 64 PUSHes from engine 1, then PUSH from engine 2 → err=1, o_free_cnt=0; POP engine 2 → err=1, dat=0.
- Engine 3 holds 5 entries, CLR → acks 0 for 5 cycles, response at T+6 with dat=5; o_free_cnt +5; a pending engine 0 PUSH is acked at T+6.
- CLR on an empty stack → response at T+2, dat=0, err=0; acks blocked only at T+1.
- Assert arst_n mid-WALK → all outputs at reset values; subsequent 64 PUSHes succeed and the 65th reports err.
